// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Brief    : Packs instruction-field bundles into 32-bit words and writes them
//            sequentially into an instruction memory of DEPTH words.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
   parameter int DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  op_sel,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [5:0]  funct,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic [10:0] count,
   output logic        full,
   output logic        err
);

   localparam logic [10:0] c_depth    = 11'(DEPTH);
   localparam logic [10:0] c_depth_m1 = 11'(DEPTH - 1);

   localparam logic [2:0] c_op_r    = 3'd0;
   localparam logic [2:0] c_op_lw   = 3'd1;
   localparam logic [2:0] c_op_sw   = 3'd2;
   localparam logic [2:0] c_op_beq  = 3'd3;
   localparam logic [2:0] c_op_j    = 3'd4;
   localparam logic [2:0] c_op_jal  = 3'd5;
   localparam logic [2:0] c_op_nop  = 3'd6;
   localparam logic [2:0] c_op_ill  = 3'd7;

   localparam logic [5:0] c_opc_special = 6'b000000;
   localparam logic [5:0] c_opc_lw      = 6'b100011;
   localparam logic [5:0] c_opc_sw      = 6'b101011;
   localparam logic [5:0] c_opc_beq     = 6'b000100;
   localparam logic [5:0] c_opc_j       = 6'b000010;
   localparam logic [5:0] c_opc_jal     = 6'b000011;

   localparam logic [1:0] c_st_empty   = 2'd0;
   localparam logic [1:0] c_st_loading = 2'd1;
   localparam logic [1:0] c_st_full    = 2'd2;

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic [10:0] r_count;
   logic [10:0] w_count_nxt;
   logic        r_err;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;

   logic        w_full;
   logic        w_ready;
   logic        w_accept;
   logic        w_illegal;
   logic        w_write;
   logic [31:0] w_enc;

   // ---------------------------------------------------------------- handshake
   assign w_accept  = in_valid & w_ready;
   assign w_illegal = (op_sel == c_op_ill);
   assign w_write   = w_accept & ~w_illegal;

   // ----------------------------------------------------------------- encoder
   always_comb begin
      w_enc = 32'h0000_0000;
      case (op_sel)
         c_op_r:   w_enc = {c_opc_special, rs, rt, rd, shamt, funct};
         c_op_lw:  w_enc = {c_opc_lw,  rs, rt, imm};
         c_op_sw:  w_enc = {c_opc_sw,  rs, rt, imm};
         c_op_beq: w_enc = {c_opc_beq, rs, rt, imm};
         c_op_j:   w_enc = {c_opc_j,   target};
         c_op_jal: w_enc = {c_opc_jal, target};
         c_op_nop: w_enc = 32'h0000_0000;
         default:  w_enc = 32'h0000_0000;
      endcase
   end

   // ------------------------------------------------------------ FSM: register
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= c_st_empty;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------- FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_empty: begin
            if (!clear && w_write) begin
               w_state_nxt = (r_count == c_depth_m1) ? c_st_full : c_st_loading;
            end
         end
         c_st_loading: begin
            if (clear) begin
               w_state_nxt = c_st_empty;
            end else if (w_write && (r_count == c_depth_m1)) begin
               w_state_nxt = c_st_full;
            end
         end
         c_st_full: begin
            if (clear) begin
               w_state_nxt = c_st_empty;
            end
         end
         default: w_state_nxt = c_st_empty;
      endcase
   end

   // -------------------------------------------------------------- FSM: outputs
   // in_ready must drop while reset is held, hence the direct use of rst here.
   always_comb begin
      w_full  = (r_state == c_st_full);
      w_ready = rst & ~w_full & ~clear;
   end

   // --------------------------------------------------------------- datapath
   always_comb begin
      w_count_nxt = r_count;
      if (clear) begin
         w_count_nxt = 11'd0;
      end else if (w_write) begin
         w_count_nxt = r_count + 11'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count <= 11'd0;
         r_err   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= 32'h0000_0000;
         r_wdata <= 32'h0000_0000;
      end else begin
         r_count <= w_count_nxt;
         r_we    <= w_write;
         if (clear) begin
            r_err <= 1'b0;
         end else if (w_accept && w_illegal) begin
            r_err <= 1'b1;
         end
         // Address is captured from the pre-increment count so it never wraps.
         if (w_write) begin
            r_addr  <= {19'd0, r_count, 2'b00};
            r_wdata <= w_enc;
         end
      end
   end

   assign in_ready   = w_ready;
   assign full       = w_full;
   assign count      = r_count;
   assign err        = r_err;
   assign imem_we    = r_we;
   assign imem_addr  = r_addr;
   assign imem_wdata = r_wdata;

   // Depth is only used through the count comparisons above.
   logic w_unused_depth;
   assign w_unused_depth = ^c_depth;

endmodule
`default_nettype wire
